// File: rtl/row_buffer_window_if.sv
// row_buffer_window_if: pixel-stream input and window output bundle for row_buffer_window
//   buf_valid  - pix_in carries a valid pixel this cycle
//   pix_in     - incoming pixel
//   frame_rst  - restart pointer and fill count at start of frame
//   win_out    - flattened MASK_WIDTH x MASK_WIDTH window, element (r,c) at [(r*MASK_WIDTH+c)*DATA_BIT +: DATA_BIT]
//   win_valid  - win_out was updated this cycle
//   win_primed - window holds only real frame data
//   master: stream producer / window consumer; slave: the windowing block
interface row_buffer_window_if #(
    parameter int DATA_BIT   = 15,
    parameter int MASK_WIDTH = 7
);
    logic                                       buf_valid;
    logic [DATA_BIT-1:0]                        pix_in;
    logic                                       frame_rst;
    logic [MASK_WIDTH*MASK_WIDTH*DATA_BIT-1:0]  win_out;
    logic                                       win_valid;
    logic                                       win_primed;

    modport master (
        output buf_valid, pix_in, frame_rst,
        input  win_out, win_valid, win_primed
    );

    modport slave (
        input  buf_valid, pix_in, frame_rst,
        output win_out, win_valid, win_primed
    );
endinterface

// File: rtl/row_buffer_window.sv
// row_buffer_window: line-buffered MASK_WIDTH x MASK_WIDTH sliding window over a pixel stream
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset
//   bus   - slave side of row_buffer_window_if (pixel stream in, registered window out)
module row_buffer_window #(
    parameter int DATA_BIT   = 15,
    parameter int ROW_WIDTH  = 512,
    parameter int MASK_WIDTH = 7,
    parameter int ADDR_BIT   = 9,
    parameter int FILL_BIT   = 12
) (
    input  logic              clk,
    input  logic              reset,
    row_buffer_window_if.slave bus
);
    localparam int M = MASK_WIDTH;
    localparam logic [FILL_BIT-1:0] FILL = FILL_BIT'((MASK_WIDTH-1)*ROW_WIDTH+MASK_WIDTH);

    logic [ADDR_BIT-1:0]              ptr;
    logic [FILL_BIT-1:0]              fill;
    logic                             win_valid_q;
    logic [DATA_BIT-1:0]              win [M][M];
    logic [DATA_BIT-1:0]              col [M];
    logic [M*M*DATA_BIT-1:0]          win_flat;

    // A frame restart coinciding with a valid pixel makes that pixel address 0 / fill 0 of the new frame.
    wire [ADDR_BIT-1:0] addr      = bus.frame_rst ? '0 : ptr;
    wire [FILL_BIT-1:0] fill_base = bus.frame_rst ? '0 : fill;

    assign col[M-1] = bus.pix_in;

    // Line buffer k holds the row that is (M-1-k) rows older than pix_in; each stage
    // reads before writing and passes its old pixel to the next-older stage.
    for (genvar k = 0; k < M-1; k++) begin : g_lb
        logic [DATA_BIT-1:0] mem [ROW_WIDTH];
        assign col[k] = mem[addr];
        always_ff @(posedge clk)
            if (bus.buf_valid && !reset)
                mem[addr] <= col[k+1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= '0;
            fill        <= '0;
            win_valid_q <= 1'b0;
            for (int r = 0; r < M; r++)
                for (int c = 0; c < M; c++)
                    win[r][c] <= '0;
        end else begin
            win_valid_q <= bus.buf_valid;
            if (bus.buf_valid) begin
                ptr  <= (addr == ADDR_BIT'(ROW_WIDTH-1)) ? '0 : addr + 1'b1;
                fill <= (fill_base == FILL) ? FILL : fill_base + 1'b1;
                for (int r = 0; r < M; r++) begin
                    for (int c = 0; c < M-1; c++)
                        win[r][c] <= win[r][c+1];
                    win[r][M-1] <= col[r];
                end
            end else if (bus.frame_rst) begin
                ptr  <= '0;
                fill <= '0;
            end
        end
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++)
                win_flat[(r*M+c)*DATA_BIT +: DATA_BIT] = win[r][c];
    end

    assign bus.win_out    = win_flat;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_primed = (fill == FILL);
endmodule

// File: tb/tb_row_buffer_window.sv
// tb_row_buffer_window: directed scoreboard bench for row_buffer_window (small 8/3 and default 512/7 builds)
module tb_row_buffer_window;
    localparam int DB = 15;
    localparam int SR = 8,   SM = 3;
    localparam int DR = 512, DM = 7;
    localparam int SW = SM*SM*DB, DW = DM*DM*DB;

    typedef struct {
        logic          primed;
        logic          full;
        logic [DB-1:0] br;
        logic [DW-1:0] win;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1;
    bit   d = 1'b0;
    int   tests = 0, fails = 0;
    int   hist[$];
    exp_t sbq[$];
    exp_t last;

    always #5 clk = ~clk;

    row_buffer_window_if #(.DATA_BIT(DB), .MASK_WIDTH(SM)) bs();
    row_buffer_window_if #(.DATA_BIT(DB), .MASK_WIDTH(DM)) bd();

    row_buffer_window #(.DATA_BIT(DB), .ROW_WIDTH(SR), .MASK_WIDTH(SM), .ADDR_BIT(3), .FILL_BIT(5))
        u_small (.clk(clk), .reset(reset), .bus(bs.slave));
    row_buffer_window u_dflt (.clk(clk), .reset(reset), .bus(bd.slave));

    logic          o_v, o_p;
    logic [DW-1:0] o_w;
    assign o_v = d ? bd.win_valid  : bs.win_valid;
    assign o_p = d ? bd.win_primed : bs.win_primed;
    assign o_w = d ? bd.win_out    : DW'(bs.win_out);

    function automatic logic [DB-1:0] o_br();
        return o_w[((d ? DM*DM : SM*SM)-1)*DB +: DB];
    endfunction

    // Reference window: element (r,c) is the frame pixel (M-1-r) rows and (M-1-c) pixels older than the newest.
    function automatic logic [DW-1:0] ref_win(input int h[$], input int m, input int rw);
        logic [DW-1:0] w;
        int n;
        w = '0;
        n = h.size() - 1;
        for (int r = 0; r < m; r++)
            for (int c = 0; c < m; c++)
                w[(r*m+c)*DB +: DB] = DB'(h[n-(m-1-r)*rw-(m-1-c)]);
        return w;
    endfunction

    function automatic logic [DW-1:0] win3(input int a, input int b, input int c);
        int s[3];
        logic [DW-1:0] w;
        s = '{a, b, c};
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                w[(r*3+k)*DB +: DB] = DB'(s[r] + k);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int pix, input logic fr);
        if (d) begin
            bd.buf_valid = v; bd.pix_in = DB'(pix); bd.frame_rst = fr;
        end else begin
            bs.buf_valid = v; bs.pix_in = DB'(pix); bs.frame_rst = fr;
        end
    endtask

    task automatic step(input logic v, input int pix, input logic fr);
        int   m, rw, fl;
        exp_t e;
        m  = d ? DM : SM;
        rw = d ? DR : SR;
        fl = (m-1)*rw + m;
        drive(v, pix, fr);
        if (fr) hist.delete();
        if (v) begin
            hist.push_back(pix);
            e.primed = hist.size() >= fl;
            e.full   = e.primed;
            e.br     = DB'(pix);
            e.win    = e.full ? ref_win(hist, m, rw) : '0;
            sbq.push_back(e);
            last = e;
        end
        @(posedge clk); #1;
        chk("valid", o_v, v);
        if (o_v && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("primed", o_p, e.primed);
            if (e.full) chk("window", o_w, e.win);
            else        chk("newest", o_br(), e.br);
        end else if (!o_v) begin
            chk("idle_primed", o_p, hist.size() >= fl);
            if (last.full) chk("hold_window", o_w, last.win);
            else           chk("hold_newest", o_br(), last.br);
        end
    endtask

    task automatic do_reset(input logic v, input int pix);
        drive(v, pix, 1'b0);
        reset = 1'b1;
        hist.delete();
        sbq.delete();
        last.primed = 1'b0; last.full = 1'b1; last.br = '0; last.win = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_valid", o_v, 1'b0);
        chk("rst_primed", o_p, 1'b0);
        chk("rst_window", o_w, '0);
    endtask

    initial begin
        bs.buf_valid = 0; bs.pix_in = '0; bs.frame_rst = 0;
        bd.buf_valid = 0; bd.pix_in = '0; bd.frame_rst = 0;
        d = 1'b0;
        do_reset(1'b0, 0);
        for (int i = 0; i <= 18; i++) step(1'b1, i, 1'b0);
        chk("s1_primed", o_p, 1'b1);
        chk("s1_window", o_w, win3(0, 8, 16));
        for (int i = 19; i <= 23; i++) step(1'b1, i, 1'b0);
        chk("s2_window", o_w, win3(5, 13, 21));
        step(1'b1, 24, 1'b0);
        chk("s2_wrap", o_w, win3(6, 14, 22));
        for (int i = 25; i <= 99; i++) step(1'b1, i, 1'b0);
        step(1'b1, 100, 1'b1);
        chk("s4_unprimed", o_p, 1'b0);
        for (int i = 101; i <= 118; i++) step(1'b1, i, 1'b0);
        chk("s4_primed", o_p, 1'b1);
        chk("s4_window", o_w, win3(100, 108, 116));
        step(1'b0, 0, 1'b1);
        for (int i = 119; i <= 124; i++) step(1'b1, i, 1'b0);
        do_reset(1'b1, 125);
        step(1'b1, 126, 1'b0);
        chk("s5_newest", o_br(), DB'(126));
        do_reset(1'b0, 0);
        for (int i = 0; i <= 18; i++) begin
            step(1'b1, i, 1'b0);
            step(1'b0, 0, 1'b0);
        end
        chk("s3_primed", o_p, 1'b1);
        chk("s3_window", o_w, win3(0, 8, 16));
        drive(1'b0, 0, 1'b0);
        d = 1'b1;
        do_reset(1'b0, 0);
        for (int i = 0; i < 3600; i++) begin
            step(1'b1, i, 1'b0);
            if (i % 97 == 50) step(1'b0, 0, 1'b0);
        end
        chk("d_primed", o_p, 1'b1);
        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
